iter_right_shifter: RTL and testbench
=====================================

// Module: iter_right_shifter
// PURPOSE
//   Multi-cycle shift unit for the ALU path: SRL/SRA (optionally SLL) of an
//   N-bit operand, one bit position per clock.
//   Trades latency for area versus a full barrel shifter.
//   Start/done handshake to the execute-stage controller; result held stable until next start.
// PARAMETERS
//   N        32            operand/result width
//   SHAMT_W  $clog2(N)     shift-amount width (5 for N=32)
// PORTS
//   clk    in   1        rising-edge clock, single clock domain
//   rst    in   1        synchronous, active-high reset
//   start  in   1        request; sampled only when not busy
//   A      in   N        operand, captured on accepted start
//   shamt  in   SHAMT_W  shift amount, captured on accepted start
//   op     in   2        00=SRL, 01=SRA, 10=SLL (only with macro), 11=reserved
//   busy   out  1        high while shifting; start ignored
//   done   out  1        one-cycle pulse: B valid
//   B      out  N        result register; holds value until next accepted start
// BEHAVIOUR
//   - Reset (sync, rst=1 at edge): state=IDLE, B=0, busy=0, done=0, count=0. Overrides all.
//   - FSM states IDLE, SHIFT, DONE. DONE lasts exactly one cycle, then IDLE.
//   - IDLE/DONE + start=1: B<=A, count<=shamt, op latched.
//       shamt==0 -> DONE next cycle; else -> SHIFT.
//   - SHIFT: each cycle B<=step(B), count<=count-1; when count==1 -> DONE.
//       SRL fill 0; SRA fill B[N-1] (sign preserved); SLL {B[N-2:0],1'b0}.
//   - Latency: start edge t -> done=1 in cycle t+shamt+1 (shamt=0 -> t+1).
//   - busy=1 exactly in SHIFT cycles (shamt cycles); done=1 only in DONE.
//   - start while busy: ignored, no queuing; A/shamt/op changes mid-op ignored.
//   - start in the DONE cycle: accepted (back-to-back ops, no idle bubble).
//   - shamt=N-1 max: SRA of negative -> all ones; SRL -> 0 or 1.
//   - op=11 (or 10 without macro): B<=A, shamt ignored, done at t+1.
//   - rst mid-SHIFT: abort, B=0 next cycle, no done pulse.
// CONFIGURATION
//   Macro ITER_SHIFT_SLL_EN:
//     defined   -> op=10 performs logical left shift, same timing as SRL/SRA.
//     undefined -> op=10 treated as reserved (B<=A, done at t+1); no left-step logic built.
// STRUCTURE
//   - Package shift_pkg: localparams SHIFT_SRL=2'b00, SHIFT_SRA=2'b01,
//     SHIFT_SLL=2'b10, SHIFT_RSV=2'b11; FSM state encodings
//     ST_IDLE/ST_SHIFT/ST_DONE.
//   - One sub-module shift1_step (combinational, param N): inputs value, op;
//     output value shifted one position with correct fill.
//   - Top holds FSM, count register, B register.
// TESTING
//   1. SRL A=32'h8000_0000, shamt=4 -> done at t+5, B=32'h0800_0000, busy 4 cycles.
//   2. SRA A=32'hF000_0000, shamt=31 -> done at t+32, B=32'hFFFF_FFFF.
//   3. shamt=0, op=SRA, A=32'h1234_5678 -> done at t+1, B=32'h1234_5678, busy never high.
//   4. start during busy with A=0 -> ignored; first result intact;
//      start in DONE cycle -> accepted, second done at expected cycle.
//   5. rst at 2nd SHIFT cycle of shamt=10 -> next cycle B=0, busy=0, no done pulse.
//   6. op=10, A=32'h0000_0001, shamt=3: with macro -> B=32'h0000_0008 at t+4;
//      without -> B=32'h0000_0001 at t+1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: operation codes, FSM state
// encodings and the decode of which op codes actually shift.
// Optional feature macro: ITER_SHIFT_SLL_EN (enables op=10 as logical left shift).
package shift_pkg;

   localparam logic [1:0] SHIFT_SRL = 2'b00;
   localparam logic [1:0] SHIFT_SRA = 2'b01;
   localparam logic [1:0] SHIFT_SLL = 2'b10;
   localparam logic [1:0] SHIFT_RSV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Ops that take one cycle per bit position; everything else is a pass-through
   function automatic logic is_shift_op(input logic [1:0] op_code);
`ifdef ITER_SHIFT_SLL_EN
      return (op_code != SHIFT_RSV);
`else
      return (op_code == SHIFT_SRL) || (op_code == SHIFT_SRA);
`endif
   endfunction

endpackage

// File: rtl/iter_right_shifter_shift1_step.sv
// Single-position shift slice used by the iterative shifter. Pure
// combinational; the fill bit depends on the operation.
// Optional feature macro: ITER_SHIFT_SLL_EN (builds the left-step path).
module shift1_step
   import shift_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] value,
   input  logic [1:0]   op,
   output logic [N-1:0] result
);

   // Select one-bit shift direction and fill; unknown ops pass the value through
   always_comb begin
      result = value;
      case (op)
         SHIFT_SRL: result = {1'b0, value[N-1:1]};
         SHIFT_SRA: result = {value[N-1], value[N-1:1]};
`ifdef ITER_SHIFT_SLL_EN
         SHIFT_SLL: result = {value[N-2:0], 1'b0};
`endif
         default:   result = value;
      endcase
   end

endmodule

// File: rtl/iter_right_shifter.sv
// Multi-cycle shift unit: shifts the captured operand one bit per clock
// under a start/busy/done handshake. The result register holds its value
// until the next accepted start.
// Optional feature macro: ITER_SHIFT_SLL_EN (op=10 becomes logical left shift;
// otherwise op=10 behaves as reserved pass-through).
module iter_right_shifter
   import shift_pkg::*;
#(
   parameter int N       = 32,
   parameter int SHAMT_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N-1:0]       A,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         op,
   output logic               busy,
   output logic               done,
   output logic [N-1:0]       B
);

   state_t             state;
   state_t             state_nxt;
   logic [SHAMT_W-1:0] count;
   logic [SHAMT_W-1:0] count_nxt;
   logic [1:0]         op_q;
   logic [1:0]         op_nxt;
   logic [N-1:0]       b_nxt;
   logic [N-1:0]       step_val;

   shift1_step #(.N(N)) u_step (
      .value  (B),
      .op     (op_q),
      .result (step_val)
   );

   // State, remaining-count, latched op and result registers; reset wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         count <= '0;
         op_q  <= SHIFT_SRL;
         B     <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         op_q  <= op_nxt;
         B     <= b_nxt;
      end
   end

   // Next-state and datapath: accept start outside SHIFT, step once per SHIFT cycle
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      op_nxt    = op_q;
      b_nxt     = B;
      case (state)
         ST_IDLE, ST_DONE: begin
            state_nxt = ST_IDLE;
            if (start) begin
               b_nxt  = A;
               op_nxt = op;
               if (is_shift_op(op) && (shamt != '0)) begin
                  count_nxt = shamt;
                  state_nxt = ST_SHIFT;
               end else begin
                  count_nxt = '0;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            b_nxt     = step_val;
            count_nxt = count - SHAMT_W'(1);
            if (count == SHAMT_W'(1)) begin
               state_nxt = ST_DONE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy = (state == ST_SHIFT);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_iter_right_shifter.sv
// Self-checking bench for iter_right_shifter: table of vectors driven through
// a scoreboard queue, plus hand-written back-to-back and reset-abort sequences.
// Optional feature macro: ITER_SHIFT_SLL_EN (changes op=10 expectations).
module tb_iter_right_shifter;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] A;
   logic [4:0]  shamt;
   logic [1:0]  op;
   logic        busy;
   logic        done;
   logic [31:0] B;

   int cyc      = 0;
   int busy_cnt = 0;
   int checks   = 0;
   int passes   = 0;

   typedef struct {
      logic [31:0] b;
      int          cyc;
      int          busy;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [4:0]  sh;
      logic [1:0]  op;
      logic [31:0] exp_b;
      int          lat;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[10];

   iter_right_shifter #(.N(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .shamt (shamt),
      .op    (op),
      .busy  (busy),
      .done  (done),
      .B     (B)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to time done pulses
   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act === exp_v) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_v);
   endtask

   task automatic failNow(input string name);
      checks++;
      $display("[TB] FAIL %s", name);
   endtask

   // Scoreboard monitor: each done pulse pops one expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               failNow("unexpected_done");
            end else begin
               e = sb.pop_front();
               checkOutput("B", B, e.b);
               checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
               checkOutput("busy_cycles", 32'(busy_cnt), 32'(e.busy));
            end
            busy_cnt = 0;
         end
      end
   end

   // Drive one start pulse from a negedge and register its expectation
   task automatic applyStimulus(input logic [31:0] a_v, input logic [4:0] sh_v, input logic [1:0] op_v,
                                input logic [31:0] exp_b, input int lat);
      exp_t e;
      A     = a_v;
      shamt = sh_v;
      op    = op_v;
      start = 1'b1;
      e.b    = exp_b;
      e.cyc  = cyc + 1 + lat;
      e.busy = lat;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         failNow("done_timeout");
         sb.delete();
      end
   endtask

   initial begin
      exp_t e;
      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      shamt = '0;
      op    = 2'b00;

      vecs[0] = '{32'h8000_0000, 5'd4,  2'b00, 32'h0800_0000, 4};
      vecs[1] = '{32'hF000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF, 31};
      vecs[2] = '{32'h1234_5678, 5'd0,  2'b01, 32'h1234_5678, 0};
      vecs[3] = '{32'hFFFF_FFFF, 5'd31, 2'b00, 32'h0000_0001, 31};
      vecs[4] = '{32'h7FFF_FFFF, 5'd31, 2'b01, 32'h0000_0000, 31};
      vecs[5] = '{32'h8000_0000, 5'd1,  2'b01, 32'hC000_0000, 1};
      vecs[6] = '{32'hDEAD_BEEF, 5'd7,  2'b11, 32'hDEAD_BEEF, 0};
`ifdef ITER_SHIFT_SLL_EN
      vecs[7] = '{32'h0000_0001, 5'd3,  2'b10, 32'h0000_0008, 3};
`else
      vecs[7] = '{32'h0000_0001, 5'd3,  2'b10, 32'h0000_0001, 0};
`endif
      vecs[8] = '{32'hA5A5_A5A5, 5'd8,  2'b00, 32'h00A5_A5A5, 8};
      vecs[9] = '{32'h8765_4321, 5'd12, 2'b01, 32'hFFF8_7654, 12};

      repeat (2) @(negedge clk);
      checkOutput("reset_B", B, 32'h0);
      checkOutput("reset_busy", {31'b0, busy}, 32'h0);
      checkOutput("reset_done", {31'b0, done}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].a, vecs[i].sh, vecs[i].op, vecs[i].exp_b, vecs[i].lat);
         drain();
      end

      // Start while busy is ignored; start during the DONE cycle is accepted
      A     = 32'h8000_0000;
      shamt = 5'd4;
      op    = 2'b00;
      start = 1'b1;
      e.b    = 32'h0800_0000;
      e.cyc  = cyc + 1 + 4;
      e.busy = 4;
      sb.push_back(e);
      @(negedge clk);
      A     = 32'h0;
      shamt = 5'd0;
      op    = 2'b01;
      repeat (4) @(negedge clk);
      A     = 32'h0000_F000;
      shamt = 5'd2;
      op    = 2'b01;
      e.b    = 32'h0000_3C00;
      e.cyc  = cyc + 1 + 2;
      e.busy = 2;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (2) @(negedge clk);

      // Reset during the second SHIFT cycle aborts with no done pulse
      A     = 32'hFFFF_FFFF;
      shamt = 5'd10;
      op    = 2'b00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_B", B, 32'h0);
      checkOutput("abort_busy", {31'b0, busy}, 32'h0);
      checkOutput("abort_done", {31'b0, done}, 32'h0);
      rst = 1'b0;
      repeat (14) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
